// File: rtl/serial_adder_serializer_if.sv
// Parallel operand-pair handshake and LSB-first serial bit stream of the serializer.
interface serial_adder_serializer_if #(
    parameter int unsigned WIDTH = 8
);
    logic             in_vld;
    logic             in_rdy;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic             vld;
    logic             a;
    logic             b;
    logic             last;
    logic             busy;

    modport master (
        output in_vld, in_a, in_b,
        input  in_rdy, vld, a, b, last, busy
    );

    modport slave (
        input  in_vld, in_a, in_b,
        output in_rdy, vld, a, b, last, busy
    );
endinterface

// File: rtl/serial_adder_serializer.sv
// Converts accepted parallel operand pairs into an LSB-first serial bit-pair stream,
// with one pending slot so back-to-back pairs stream without bubbles.
module serial_adder_serializer #(
    parameter int unsigned WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    serial_adder_serializer_if.slave bus
);
    localparam int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    typedef enum logic {IDLE = 1'b0, SHIFT = 1'b1} state_t;

    state_t           state;
    state_t           state_nx;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] act_a;
    logic [WIDTH-1:0] act_b;
    logic [WIDTH-1:0] pend_a;
    logic [WIDTH-1:0] pend_b;
    logic             pend_full;
    logic             accept;
    logic             pair_end;

    assign accept   = bus.in_vld && bus.in_rdy;
    assign pair_end = (state == SHIFT) && (cnt == CNT_LAST);

    // State register
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    // Next-state logic: leave SHIFT only when nothing follows the current pair
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (accept) state_nx = SHIFT;
            SHIFT:   if (pair_end && !pend_full && !accept) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Active shift registers (bit 0 is the current output bit), counter and pending slot
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt       <= '0;
            pend_full <= 1'b0;
            act_a     <= '0;
            act_b     <= '0;
            pend_a    <= '0;
            pend_b    <= '0;
        end else if (state == IDLE) begin
            if (accept) begin
                act_a <= bus.in_a;
                act_b <= bus.in_b;
                cnt   <= '0;
            end
        end else if (pair_end) begin
            cnt <= '0;
            if (pend_full) begin
                act_a     <= pend_a;
                act_b     <= pend_b;
                pend_full <= 1'b0;
            end else if (accept) begin
                act_a <= bus.in_a;
                act_b <= bus.in_b;
            end
        end else begin
            act_a <= act_a >> 1;
            act_b <= act_b >> 1;
            cnt   <= cnt + CNT_W'(1);
            if (accept) begin
                pend_a    <= bus.in_a;
                pend_b    <= bus.in_b;
                pend_full <= 1'b1;
            end
        end
    end

    // Outputs decoded from registered state; in_rdy also gated by rst
    always_comb begin
        bus.vld    = 1'b0;
        bus.a      = 1'b0;
        bus.b      = 1'b0;
        bus.last   = 1'b0;
        bus.busy   = pend_full;
        bus.in_rdy = !pend_full && !rst;
        if (state == SHIFT) begin
            bus.vld  = 1'b1;
            bus.a    = act_a[0];
            bus.b    = act_b[0];
            bus.last = (cnt == CNT_LAST);
            bus.busy = 1'b1;
        end
    end
endmodule

// File: tb/tb_serial_adder_serializer.sv
// Scoreboard bench: expected serial bits and downstream sums are queued on acceptance
// and checked by an independent negedge monitor.
module tb_serial_adder_serializer;
    localparam int unsigned W = 4;

    logic clk;
    logic rst;
    serial_adder_serializer_if #(.WIDTH(W)) bus ();

    serial_adder_serializer #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    bit mon_en   = 1'b0;
    bit carry    = 1'b0;

    // Entry: {a, b, last, sum}
    logic [3:0] exp_q[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, expv);
        end
    endtask

    // Reference: pair streams index 0..W-1; downstream sum bit i is bit i of a+b
    task automatic push_pair(input logic [W-1:0] av, input logic [W-1:0] bv);
        int unsigned sum;
        sum = int'(av) + int'(bv);
        for (int i = 0; i < int'(W); i++)
            exp_q.push_back({av[i], bv[i], (i == int'(W) - 1), 1'((sum >> i) & 1)});
    endtask

    // Monitor: vld/busy iff bits outstanding; in_rdy low iff a second pair is held
    always @(negedge clk) begin
        if (mon_en) begin
            logic [3:0] e;
            logic       s;
            chk("vld", 64'(bus.vld), 64'(exp_q.size() > 0));
            chk("busy", 64'(bus.busy), 64'(exp_q.size() > 0));
            chk("in_rdy", 64'(bus.in_rdy), 64'(!(exp_q.size() > int'(W)) && !rst));
            if (bus.vld === 1'b1 && exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("a_bit", 64'(bus.a), 64'(e[3]));
                chk("b_bit", 64'(bus.b), 64'(e[2]));
                chk("last", 64'(bus.last), 64'(e[1]));
                s = bus.a ^ bus.b ^ carry;
                chk("sum_bit", 64'(s), 64'(e[0]));
                carry = (bus.a & bus.b) | (bus.a & carry) | (bus.b & carry);
                if (bus.last === 1'b1) carry = 1'b0;
            end else if (bus.vld !== 1'b1) begin
                chk("idle_abl", 64'({bus.a, bus.b, bus.last}), 64'(0));
            end
            if (rst) begin
                exp_q.delete();
                carry = 1'b0;
            end
        end
    end

    // All driver tasks start and end at posedge+1
    task automatic idle(input int n);
        bus.in_vld = 1'b0;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send(input logic [W-1:0] av, input logic [W-1:0] bv);
        bit acc;
        bit done;
        bus.in_a   = av;
        bus.in_b   = bv;
        bus.in_vld = 1'b1;
        done       = 1'b0;
        for (int t = 0; t < 40 && !done; t++) begin
            @(negedge clk);
            acc = (bus.in_rdy === 1'b1) && !rst;
            @(posedge clk);
            if (acc) begin
                push_pair(av, bv);
                done = 1'b1;
            end
            #1;
        end
        if (!done) begin
            n_checks++;
            n_errors++;
            $display("FAIL accept_timeout at %0t: pair %0h/%0h never accepted", $time, av, bv);
        end
    endtask

    task automatic pulse_rst(input int n, input bit vld_during);
        rst        = 1'b1;
        bus.in_vld = vld_during;
        bus.in_a   = 4'b1010;
        bus.in_b   = 4'b0101;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
        rst        = 1'b0;
        bus.in_vld = 1'b0;
    endtask

    initial begin
        rst        = 1'b1;
        bus.in_vld = 1'b0;
        bus.in_a   = '0;
        bus.in_b   = '0;
        repeat (2) @(posedge clk);
        #1;
        rst    = 1'b0;
        mon_en = 1'b1;
        idle(2);

        // Single pair into IDLE
        send(4'b1011, 4'b0110);
        idle(6);

        // in_vld held high across three pairs; later offers wait on in_rdy
        send(4'b1001, 4'b0011);
        send(4'b0110, 4'b1111);
        send(4'b1110, 4'b0001);
        idle(14);

        // Reset during bit 2 with pending full
        send(4'b1101, 4'b0101);
        send(4'b0111, 4'b1000);
        bus.in_vld = 1'b0;
        @(posedge clk);
        #1;
        pulse_rst(1, 1'b0);
        @(negedge clk);
        chk("post_rst_vld", 64'(bus.vld), 64'(0));
        chk("post_rst_busy", 64'(bus.busy), 64'(0));
        chk("post_rst_rdy", 64'(bus.in_rdy), 64'(1));
        @(posedge clk);
        #1;
        send(4'b0100, 4'b1100);
        idle(6);

        // in_vld during reset is ignored
        pulse_rst(3, 1'b1);
        idle(8);

        // Downstream adder: carry must clear between pairs
        send(4'b1111, 4'b0001);
        send(4'b0011, 4'b0001);
        idle(10);

        // Randomized traffic with random gaps
        for (int k = 0; k < 120; k++) begin
            if ($urandom_range(0, 3) == 0) idle(int'($urandom_range(1, 6)));
            send(4'($urandom), 4'($urandom));
        end
        idle(12);
        chk("drained", 64'(exp_q.size()), 64'(0));

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
